// File: rtl/pad_pkg.sv
// pad_pkg: shared definitions for the Mega Drive pad poller.
//   - button bit positions inside the 12-bit active-high button vector
//   - poller state enum
//   - TH phase indices (H1 L1 H2 L2 H3 L3 H4 L4)
// Configuration macro: PAD_READER_SIXBTN_EN selects the full 8-phase
// handshake; without it only H1 and L1 are driven.
package pad_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_MODE  = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_Y     = 10;
    localparam int BTN_Z     = 11;

    typedef enum logic [1:0] {
        IDLE,
        PHASE,
        DONE
    } state_t;

    // Even phases drive TH high, odd phases drive it low.
    localparam logic [2:0] H1 = 3'd0;
    localparam logic [2:0] L1 = 3'd1;
    localparam logic [2:0] H2 = 3'd2;
    localparam logic [2:0] L2 = 3'd3;
    localparam logic [2:0] H3 = 3'd4;
    localparam logic [2:0] L3 = 3'd5;
    localparam logic [2:0] H4 = 3'd6;
    localparam logic [2:0] L4 = 3'd7;

`ifdef PAD_READER_SIXBTN_EN
    localparam logic [2:0] LAST_PHASE = L4;
`else
    localparam logic [2:0] LAST_PHASE = L1;
`endif

endpackage

// File: rtl/pad_sync.sv
// pad_sync: parameterised-width two-flop synchronizer.
// Ports:
//   clk    core clock
//   reset  asynchronous, active-high reset (flops go to all ones, the
//          released level of the active-low pad pins)
//   d      asynchronous input bus
//   q      synchronized output bus
module pad_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_reader.sv
// pad_reader: host-side Mega Drive controller-port poller.
// Every POLL_CYC clocks (while poll_en=1) it walks TH through the
// handshake phases, each SETTLE_CYC clocks long, samples D5..D0 at the
// end of each phase and decodes 3-button / 6-button pads.
// Ports:
//   clk      core clock
//   reset    asynchronous, active-high reset
//   poll_en  enables starting new polls (a running poll always completes)
//   pad_in   connector D5..D0, raw, active-low
//   th_out   TH level driven to the pad (registered)
//   th_oe    TH output enable
//   buttons  active-high {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}
//   present  pad detected on the last poll
//   six_btn  6-button pad detected on the last poll
//   valid    one-cycle pulse when buttons/present/six_btn update
// Configuration macro: PAD_READER_SIXBTN_EN enables the 8-phase
// sequence and 6-button decode; otherwise only H1/L1 are driven.
module pad_reader
    import pad_pkg::*;
#(
    parameter int SETTLE_CYC = 128,
    parameter int POLL_CYC   = 894886
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        poll_en,
    input  logic [5:0]  pad_in,
    output logic        th_out,
    output logic        th_oe,
    output logic [11:0] buttons,
    output logic        present,
    output logic        six_btn,
    output logic        valid
);

    localparam int PW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t        state, state_n;
    logic [2:0]    phase, phase_n;
    logic [SW-1:0] settle_cnt, settle_n;
    logic [PW-1:0] poll_cnt;
    logic          poll_wrap;
    logic          sample_en;
    logic          load_out;
    logic          th_n;
    logic [5:0]    pad_s;

    logic [5:0]    cap_h1;
    logic [3:0]    cap_l1;    // L1 D5..D2
`ifdef PAD_READER_SIXBTN_EN
    logic [3:0]    cap_l3;    // L3 D3..D0
    logic [3:0]    cap_h4;    // H4 D3..D0
`endif

    logic [11:0]   btn_d;
    logic          present_d;
    logic          six_d;

    pad_sync #(.WIDTH(6)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pad_in),
        .q     (pad_s)
    );

    assign poll_wrap = (poll_cnt == PW'(POLL_CYC - 1));

    // The poll counter free-runs in every state so poll starts stay on a
    // fixed POLL_CYC grid measured from reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= '0;
        end else if (poll_wrap) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= H1;
            settle_cnt <= '0;
            th_out     <= 1'b1;
            th_oe      <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            settle_cnt <= settle_n;
            th_out     <= th_n;
            th_oe      <= 1'b1;
        end
    end

    // TH is derived from the next state/phase so the registered th_out
    // changes on the first cycle of each phase.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        settle_n  = settle_cnt;
        sample_en = 1'b0;
        load_out  = 1'b0;
        case (state)
            IDLE: begin
                if (poll_wrap && poll_en) begin
                    state_n  = PHASE;
                    phase_n  = H1;
                    settle_n = '0;
                end
            end
            PHASE: begin
                if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                    sample_en = 1'b1;
                    settle_n  = '0;
                    if (phase == LAST_PHASE) begin
                        state_n = DONE;
                    end else begin
                        phase_n = phase + 3'd1;
                    end
                end else begin
                    settle_n = settle_cnt + 1'b1;
                end
            end
            DONE: begin
                load_out = 1'b1;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        th_n = (state_n == PHASE) ? ~phase_n[0] : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_h1 <= '1;
            cap_l1 <= '1;
`ifdef PAD_READER_SIXBTN_EN
            cap_l3 <= '1;
            cap_h4 <= '1;
`endif
        end else if (sample_en) begin
            case (phase)
                H1:      cap_h1 <= pad_s;
                L1:      cap_l1 <= pad_s[5:2];
`ifdef PAD_READER_SIXBTN_EN
                L3:      cap_l3 <= pad_s[3:0];
                H4:      cap_h4 <= pad_s[3:0];
`endif
                default: ;
            endcase
        end
    end

    // A pad pulls D3:D2 low while TH is low; a 6-button pad additionally
    // pulls D3..D0 low in L3. Pins are active-low, buttons active-high.
    always_comb begin
        btn_d     = '0;
        present_d = (cap_l1[1:0] == 2'b00);
`ifdef PAD_READER_SIXBTN_EN
        six_d     = present_d && (cap_l3 == 4'b0000);
`else
        six_d     = 1'b0;
`endif
        if (present_d) begin
            btn_d[BTN_UP]    = ~cap_h1[0];
            btn_d[BTN_DOWN]  = ~cap_h1[1];
            btn_d[BTN_LEFT]  = ~cap_h1[2];
            btn_d[BTN_RIGHT] = ~cap_h1[3];
            btn_d[BTN_B]     = ~cap_h1[4];
            btn_d[BTN_C]     = ~cap_h1[5];
            btn_d[BTN_A]     = ~cap_l1[2];
            btn_d[BTN_START] = ~cap_l1[3];
        end
`ifdef PAD_READER_SIXBTN_EN
        if (six_d) begin
            btn_d[BTN_Z]    = ~cap_h4[0];
            btn_d[BTN_Y]    = ~cap_h4[1];
            btn_d[BTN_X]    = ~cap_h4[2];
            btn_d[BTN_MODE] = ~cap_h4[3];
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buttons <= '0;
            present <= 1'b0;
            six_btn <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= load_out;
            if (load_out) begin
                buttons <= btn_d;
                present <= present_d;
                six_btn <= six_d;
            end
        end
    end

endmodule
